// File: rtl/agc_pwm_gen_if.sv
// AGC/PWM control bus: loop configuration and estimator strobe in, gain code and pins out.
interface agc_pwm_gen_if #(
  parameter int unsigned DB_WID = 9
);
  logic              agc_en;
  logic [DB_WID-1:0] pwr_est_dB;
  logic              pwr_est_end;
  logic [DB_WID-1:0] pwr_target;
  logic [3:0]        pwr_window;
  logic [1:0]        pwm_step;
  logic              pwm_ena;
  logic              pwm_inv;
  logic              pwm_th_ena;
  logic [6:0]        pwm_th_in;
  logic [6:0]        pwm_max_val;
  logic [6:0]        pwm_th_out;
  logic              pwm_out;
  logic              agc_fix;

  modport master (
    output agc_en, pwr_est_dB, pwr_est_end, pwr_target, pwr_window, pwm_step,
           pwm_ena, pwm_inv, pwm_th_ena, pwm_th_in, pwm_max_val,
    input  pwm_th_out, pwm_out, agc_fix
  );

  modport slave (
    input  agc_en, pwr_est_dB, pwr_est_end, pwr_target, pwr_window, pwm_step,
           pwm_ena, pwm_inv, pwm_th_ena, pwm_th_in, pwm_max_val,
    output pwm_th_out, pwm_out, agc_fix
  );
endinterface

// File: rtl/agc_pwm_gen.sv
// AGC loop filter: steps a 7-bit gain code from dB power estimates, tracks lock,
// and drives a 128-step PWM whose duty is the gain code.
module agc_pwm_gen #(
  parameter int unsigned DB_WID     = 9,
  parameter int unsigned PWM_INIT   = 64,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 2
) (
  input logic          clk,
  input logic          reset_n,
  agc_pwm_gen_if.slave agc
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StTrack, StLocked} state_e;

  state_e              state_q;
  logic [6:0]          code_q;
  logic                fix_q;
  logic [CntW-1:0]     in_cnt_q;
  logic [CntW-1:0]     miss_cnt_q;
  logic [6:0]          pwm_cnt_q;
  logic [6:0]          duty_q;
  logic                pwm_q;

  logic signed [DB_WID:0] err;
  logic signed [DB_WID:0] win;
  logic                   above;
  logic                   below;
  logic [3:0]             step;
  logic [6:0]             base;
  logic [7:0]             sum;
  logic [6:0]             code_up;
  logic [6:0]             code_dn;
  logic [6:0]             code_adj;
  logic [6:0]             th_clamp;
  logic [CntW-1:0]        in_inc;
  logic [CntW-1:0]        miss_inc;

  // Error classification and saturating up/down candidates for the next gain code.
  always_comb begin
    err      = $signed({1'b0, agc.pwr_est_dB}) - $signed({1'b0, agc.pwr_target});
    win      = $signed({{(DB_WID - 3){1'b0}}, agc.pwr_window});
    above    = err > win;
    below    = err < -win;
    step     = (state_q == StLocked) ? 4'd1 : (4'd1 << agc.pwm_step);
    // A lowered ceiling pulls the code down before it is stepped.
    base     = (code_q > agc.pwm_max_val) ? agc.pwm_max_val : code_q;
    sum      = {1'b0, base} + {4'b0, step};
    code_up  = (sum > {1'b0, agc.pwm_max_val}) ? agc.pwm_max_val : sum[6:0];
    code_dn  = ({3'b0, step} > base) ? 7'd0 : base - {3'b0, step};
    code_adj = above ? code_dn : (below ? code_up : base);
    th_clamp = (agc.pwm_th_in > agc.pwm_max_val) ? agc.pwm_max_val : agc.pwm_th_in;
    in_inc   = in_cnt_q + 1'b1;
    miss_inc = miss_cnt_q + 1'b1;
  end

  // Loop FSM: gain code, lock flag and in-band/miss counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      code_q     <= 7'(PWM_INIT);
      fix_q      <= 1'b0;
      in_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else if (agc.pwm_th_ena) begin
      state_q    <= StIdle;
      code_q     <= th_clamp;
      fix_q      <= 1'b0;
      in_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else if (!agc.agc_en) begin
      state_q    <= StIdle;
      fix_q      <= 1'b0;
      in_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StTrack;
          fix_q   <= 1'b0;
        end
        StTrack: begin
          if (agc.pwr_est_end) begin
            code_q <= code_adj;
            if (above || below) begin
              in_cnt_q <= '0;
            end else if (in_inc == CntW'(LOCK_CNT)) begin
              state_q    <= StLocked;
              fix_q      <= 1'b1;
              in_cnt_q   <= '0;
              miss_cnt_q <= '0;
            end else begin
              in_cnt_q <= in_inc;
            end
          end
        end
        StLocked: begin
          if (agc.pwr_est_end) begin
            code_q <= code_adj;
            if (!(above || below)) begin
              miss_cnt_q <= '0;
            end else if (miss_inc == CntW'(UNLOCK_CNT)) begin
              state_q    <= StTrack;
              fix_q      <= 1'b0;
              miss_cnt_q <= '0;
              in_cnt_q   <= '0;
            end else begin
              miss_cnt_q <= miss_inc;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          fix_q   <= 1'b0;
        end
      endcase
    end
  end

  // Free-running PWM; duty reloads only at period end so a code change never glitches a period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
      duty_q    <= 7'(PWM_INIT);
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 7'd1;
      if (pwm_cnt_q == 7'd127) begin
        duty_q <= code_q;
      end
      pwm_q <= (agc.pwm_ena & (pwm_cnt_q < duty_q)) ^ agc.pwm_inv;
    end
  end

  assign agc.pwm_th_out = code_q;
  assign agc.agc_fix    = fix_q;
  assign agc.pwm_out    = pwm_q;

endmodule

// File: tb/tb_agc_pwm_gen.sv
// Bench for agc_pwm_gen: directed scenarios plus randomized traffic against a rule-level model.
module tb_agc_pwm_gen;

  localparam int DbWid    = 9;
  localparam int PwmInit  = 64;
  localparam int LockCnt  = 3;
  localparam int UnlockCnt = 2;

  logic clk;
  logic reset_n;

  agc_pwm_gen_if #(.DB_WID(DbWid)) bus ();

  agc_pwm_gen #(
    .DB_WID    (DbWid),
    .PWM_INIT  (PwmInit),
    .LOCK_CNT  (LockCnt),
    .UNLOCK_CNT(UnlockCnt)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .agc    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: 0 idle, 1 tracking, 2 locked.
  int m_state, m_code, m_fix, m_in, m_miss;
  int m_edges, m_duty, m_pwm;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_code = PwmInit; m_fix = 0; m_in = 0; m_miss = 0;
    m_edges = 0; m_duty = PwmInit; m_pwm = 0;
  endtask

  // Advance the model by one active clock edge using the inputs currently applied.
  task automatic model_edge();
    int pos, err, win, stp, base, maxv;
    bit inb;
    maxv = int'(bus.pwm_max_val);
    pos  = m_edges % 128;
    m_pwm = ((bus.pwm_ena && (pos < m_duty)) ? 1 : 0) ^ int'(bus.pwm_inv);
    if (pos == 127) m_duty = m_code;
    m_edges++;
    if (bus.pwm_th_ena) begin
      m_code  = (int'(bus.pwm_th_in) > maxv) ? maxv : int'(bus.pwm_th_in);
      m_state = 0; m_in = 0; m_miss = 0;
    end else if (!bus.agc_en) begin
      m_state = 0; m_in = 0; m_miss = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (bus.pwr_est_end) begin
      err  = int'(bus.pwr_est_dB) - int'(bus.pwr_target);
      win  = int'(bus.pwr_window);
      stp  = (m_state == 2) ? 1 : (1 << bus.pwm_step);
      base = (m_code > maxv) ? maxv : m_code;
      inb  = (err <= win) && (err >= -win);
      if (err > win)       m_code = (base - stp < 0) ? 0 : base - stp;
      else if (err < -win) m_code = (base + stp > maxv) ? maxv : base + stp;
      else                 m_code = base;
      if (m_state == 1) begin
        if (inb) begin
          m_in++;
          if (m_in == LockCnt) begin m_state = 2; m_in = 0; m_miss = 0; end
        end else m_in = 0;
      end else begin
        if (!inb) begin
          m_miss++;
          if (m_miss == UnlockCnt) begin m_state = 1; m_miss = 0; m_in = 0; end
        end else m_miss = 0;
      end
    end
    m_fix = (m_state == 2) ? 1 : 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("code", int'(bus.pwm_th_out), m_code);
    check("fix", int'(bus.agc_fix), m_fix);
    check("pwm", int'(bus.pwm_out), m_pwm);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic strobe(input int db);
    bus.pwr_est_dB  = 9'(db);
    bus.pwr_est_end = 1'b1;
    step();
    bus.pwr_est_end = 1'b0;
    run(2);
  endtask

  // Load a code through the manual override, then hand control back to the loop.
  task automatic set_code(input int c);
    bus.pwm_th_ena = 1'b1;
    bus.pwm_th_in  = 7'(c);
    step();
    bus.pwm_th_ena = 1'b0;
    step();
  endtask

  task automatic count_period(input string tag, input int exp);
    int h;
    h = 0;
    repeat (128) begin
      step();
      h += int'(bus.pwm_out);
    end
    check(tag, h, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_code"}, int'(bus.pwm_th_out), PwmInit);
    check({tag, "_pwm"}, int'(bus.pwm_out), 0);
    check({tag, "_fix"}, int'(bus.agc_fix), 0);
  endtask

  initial begin
    int wmax;
    reset_n         = 1'b1;
    bus.agc_en      = 1'b0;
    bus.pwr_est_dB  = '0;
    bus.pwr_est_end = 1'b0;
    bus.pwr_target  = 9'd200;
    bus.pwr_window  = 4'd3;
    bus.pwm_step    = 2'd2;
    bus.pwm_ena     = 1'b1;
    bus.pwm_inv     = 1'b0;
    bus.pwm_th_ena  = 1'b0;
    bus.pwm_th_in   = '0;
    bus.pwm_max_val = 7'd127;
    #1 reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // Reset duty: half on, half off.
    count_period("t1_duty64", 64);

    // Tracking steps by 4 in each direction; in-band leaves the code alone.
    bus.agc_en = 1'b1;
    step();
    strobe(220);
    check("t2_down", int'(bus.pwm_th_out), 60);
    strobe(180);
    check("t2_up", int'(bus.pwm_th_out), 64);
    strobe(202);
    check("t2_inband", int'(bus.pwm_th_out), 64);

    // Saturation at the ceiling, at zero, and a lowered ceiling.
    set_code(68);
    bus.pwm_max_val = 7'd70;
    bus.pwm_step    = 2'd3;
    strobe(150);
    check("t3_sat_max", int'(bus.pwm_th_out), 70);
    set_code(3);
    strobe(250);
    check("t3_sat_zero", int'(bus.pwm_th_out), 0);
    set_code(60);
    bus.pwm_max_val = 7'd50;
    strobe(200);
    check("t3_lower_max", int'(bus.pwm_th_out), 50);

    // Lock after three in-band estimates, unlock after two misses.
    bus.pwm_max_val = 7'd127;
    bus.pwm_step    = 2'd2;
    bus.agc_en      = 1'b0;
    step();
    bus.agc_en = 1'b1;
    step();
    strobe(200);
    strobe(201);
    check("t4_not_yet", int'(bus.agc_fix), 0);
    strobe(199);
    check("t4_locked", int'(bus.agc_fix), 1);
    strobe(220);
    check("t4_lock_step", int'(bus.pwm_th_out), 49);
    check("t4_still", int'(bus.agc_fix), 1);
    strobe(220);
    check("t4_unlock_code", int'(bus.pwm_th_out), 48);
    check("t4_unlocked", int'(bus.agc_fix), 0);

    // Disable while locked: lock drops, code held.
    strobe(200); strobe(200); strobe(200);
    check("t6_relock", int'(bus.agc_fix), 1);
    bus.agc_en = 1'b0;
    step();
    check("t6_en_fix", int'(bus.agc_fix), 0);
    check("t6_en_code", int'(bus.pwm_th_out), 48);
    bus.agc_en = 1'b1;

    // Override clamps to the ceiling and ignores estimates.
    bus.pwm_th_ena  = 1'b1;
    bus.pwm_th_in   = 7'd100;
    bus.pwm_max_val = 7'd90;
    step();
    check("t6_ovr_code", int'(bus.pwm_th_out), 90);
    strobe(250);
    check("t6_ovr_hold", int'(bus.pwm_th_out), 90);
    check("t6_ovr_fix", int'(bus.agc_fix), 0);

    // PWM shapes, held by the override.
    bus.pwm_max_val = 7'd127;
    bus.pwm_th_in   = 7'd32;
    run(256);
    count_period("t5_duty32", 32);
    bus.pwm_inv = 1'b1;
    count_period("t5_inv", 96);
    bus.pwm_inv   = 1'b0;
    bus.pwm_th_in = 7'd100;
    run(40);
    bus.pwm_th_in = 7'd10;
    run(300);
    bus.pwm_ena = 1'b0;
    bus.pwm_inv = 1'b1;
    count_period("t5_off_inv", 128);
    bus.pwm_ena    = 1'b1;
    bus.pwm_inv    = 1'b0;
    bus.pwm_th_ena = 1'b0;
    step();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        bus.pwr_target  = 9'($urandom_range(40, 470));
        bus.pwr_window  = 4'($urandom_range(0, 7));
        bus.pwm_step    = 2'($urandom_range(0, 3));
        bus.pwm_max_val = 7'($urandom_range(10, 127));
        bus.pwm_ena     = 1'($urandom_range(0, 1));
        bus.pwm_inv     = 1'($urandom_range(0, 1));
      end
      bus.agc_en      = ($urandom_range(0, 199) != 0);
      bus.pwm_th_ena  = ($urandom_range(0, 299) == 0);
      bus.pwm_th_in   = 7'($urandom_range(0, 127));
      bus.pwr_est_end = ($urandom_range(0, 3) == 0);
      wmax = int'(bus.pwr_window) + 3;
      bus.pwr_est_dB  = 9'(int'(bus.pwr_target) + $urandom_range(0, 2 * wmax) - wmax);
      if (i == 2000) begin
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
